trivium_stream_ctrl: RTL

Sequencer and stream-cipher front end for a Trivium keystream core with a load/step interface. It loads key/IV into the core, runs the mandatory warm-up cycles, then packs keystream bits into DATA_W-bit pads and XORs them with an input data stream under valid/ready handshakes. It sits between the core instance and the byte-wide data path.

---
 rtl/trivium_pkg.sv | 17 +
 rtl/trivium_stream_ctrl.sv | 126 ++++++++++++
 2 files changed

// File: rtl/trivium_pkg.sv
// Shared constants and controller state encoding for the Trivium stream front end.
package trivium_pkg;

    localparam int KEY_W          = 80;
    localparam int IV_W           = 80;
    localparam int STATE_W        = 288;
    localparam int WARMUP_DEFAULT = 4 * STATE_W;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WARMUP,
        GATHER,
        PAD_FULL
    } ctrl_state_e;

endpackage

// File: rtl/trivium_stream_ctrl.sv
// Loads key/IV into a Trivium core, discards the warm-up keystream, then packs
// keystream bits LSB-first into pads that are XORed onto a handshaked data stream.
module trivium_stream_ctrl
    import trivium_pkg::*;
#(
    parameter int WARMUP_CYCLES = WARMUP_DEFAULT,
    parameter int DATA_W        = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [KEY_W-1:0]  key,
    input  logic [IV_W-1:0]   iv,
    output logic              busy,
    output logic              ks_ready,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              core_load,
    output logic [KEY_W-1:0]  core_key,
    output logic [IV_W-1:0]   core_iv,
    output logic              core_step,
    input  logic              core_ks
);

    localparam int WCNT_W = $clog2(WARMUP_CYCLES + 1);
    localparam int BCNT_W = $clog2(DATA_W + 1);
    localparam logic [WCNT_W-1:0] WARM_LAST = WCNT_W'(WARMUP_CYCLES - 1);
    localparam logic [BCNT_W-1:0] BIT_LAST  = BCNT_W'(DATA_W - 1);

    ctrl_state_e       state;
    ctrl_state_e       next_state;
    logic [WCNT_W-1:0] warm_cnt;
    logic [BCNT_W-1:0] bit_cnt;
    logic [DATA_W-1:0] pad;
    logic              take;

    // A restart always wins over a same-cycle transfer.
    assign in_ready = (state == PAD_FULL) && !start && (!out_valid || out_ready);
    assign take     = in_valid && in_ready;

    always_comb begin
        next_state = state;
        if (start) begin
            next_state = LOAD;
        end else begin
            case (state)
                IDLE:     next_state = IDLE;
                LOAD:     next_state = WARMUP;
                WARMUP:   if (warm_cnt == WARM_LAST) next_state = GATHER;
                GATHER:   if (bit_cnt == BIT_LAST) next_state = PAD_FULL;
                PAD_FULL: if (take) next_state = GATHER;
                default:  next_state = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Status strobes are decoded from next_state so they line up with the state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_load <= 1'b0;
            core_step <= 1'b0;
            busy      <= 1'b0;
            ks_ready  <= 1'b0;
        end else begin
            core_load <= (next_state == LOAD);
            core_step <= (next_state == WARMUP) || (next_state == GATHER);
            busy      <= (next_state == LOAD) || (next_state == WARMUP);
            ks_ready  <= (next_state == GATHER) || (next_state == PAD_FULL);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            core_key <= '0;
            core_iv  <= '0;
            warm_cnt <= '0;
            bit_cnt  <= '0;
            pad      <= '0;
        end else if (start) begin
            core_key <= key;
            core_iv  <= iv;
            warm_cnt <= '0;
            bit_cnt  <= '0;
            pad      <= '0;
        end else begin
            case (state)
                WARMUP: warm_cnt <= (warm_cnt == WARM_LAST) ? '0 : warm_cnt + 1'b1;
                GATHER: begin
                    // Shifting in at the MSB leaves the first gathered bit in pad[0].
                    pad     <= (pad >> 1) | (DATA_W'(core_ks) << (DATA_W - 1));
                    bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + 1'b1;
                end
                PAD_FULL: if (take) pad <= '0;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (start) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (take) begin
            out_valid <= 1'b1;
            out_data  <= in_data ^ pad;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
